// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// sequencer states and small decode helpers.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_UMULL = 2'b00,
    MD_SMULL = 2'b01,
    MD_UDIV  = 2'b10,
    MD_SDIV  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } md_state_e;

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_UDIV) || (op == MD_SDIV);
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_SMULL) || (op == MD_SDIV);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage interface between the decoder/hazard unit (master) and the
// multiply/divide sequencer (slave).
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
) ();

  logic             Start;
  logic [1:0]       MDOp;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             Flush;
  logic             Busy;
  logic             Done;
  logic             StallMD;
  logic [WIDTH-1:0] ResultLo;
  logic [WIDTH-1:0] ResultHi;
  logic             DivZero;

  modport master (
    output Start, MDOp, SrcA, SrcB, Flush,
    input  Busy, Done, StallMD, ResultLo, ResultHi, DivZero
  );

  modport slave (
    input  Start, MDOp, SrcA, SrcB, Flush,
    output Busy, Done, StallMD, ResultLo, ResultHi, DivZero
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the magnitude datapath: shift-add for multiply, or
// restoring trial-subtract-shift for divide. Purely combinational.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_is_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH:0]     i_rem,
  input  logic [WIDTH-1:0]   i_operand,
  output logic [2*WIDTH-1:0] o_acc,
  output logic [WIDTH:0]     o_rem
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_trial;

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
    w_shift = {i_rem[WIDTH-1:0], i_acc[WIDTH-1]};
    w_trial = {1'b0, w_shift} - {2'b00, i_operand};
    o_acc   = {w_sum, i_acc[WIDTH-1:1]};
    o_rem   = i_rem;
    if (i_is_div) begin
      // Quotient bit is set when the trial subtraction did not borrow.
      o_acc = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-2:0], ~w_trial[WIDTH+1]};
      o_rem = w_trial[WIDTH+1] ? w_shift : w_trial[WIDTH:0];
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative UMULL/SMULL/UDIV/SDIV sequencer: works on operand magnitudes for
// WIDTH cycles, fixes signs in one extra cycle, then pulses Done.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  muldiv_sequencer_if.slave  md_if
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_divzero;
  logic [WIDTH-1:0]   r_result_lo;
  logic [WIDTH-1:0]   r_result_hi;

  md_op_e             r_op;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_operand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_rem;

  md_op_e             w_op;
  logic               w_accept;
  logic               w_div_zero;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_step_acc;
  logic [WIDTH:0]     w_step_rem;
  logic [WIDTH-1:0]   w_fix_lo;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [2*WIDTH-1:0] w_neg_prod;

  assign w_op       = md_op_e'(md_if.MDOp);
  assign w_accept   = (r_state == S_IDLE) && md_if.Start && !md_if.Flush;
  assign w_div_zero = md_is_div(w_op) && (md_if.SrcB == '0);
  assign w_neg_a    = md_is_signed(w_op) && md_if.SrcA[WIDTH-1];
  assign w_neg_b    = md_is_signed(w_op) && md_if.SrcB[WIDTH-1];
  assign w_abs_a    = w_neg_a ? -md_if.SrcA : md_if.SrcA;
  assign w_abs_b    = w_neg_b ? -md_if.SrcB : md_if.SrcB;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div  (md_is_div(r_op)),
    .i_acc     (r_acc),
    .i_rem     (r_rem),
    .i_operand (r_operand),
    .o_acc     (w_step_acc),
    .o_rem     (w_step_rem)
  );

  // Sign correction applied while in FIX; INT_MIN cases fall out naturally.
  assign w_neg_prod = -r_acc;
  always_comb begin
    w_fix_lo = r_acc[WIDTH-1:0];
    w_fix_hi = r_acc[2*WIDTH-1:WIDTH];
    case (r_op)
      MD_SMULL: if (r_sign_a ^ r_sign_b) {w_fix_hi, w_fix_lo} = w_neg_prod;
      MD_UDIV:  w_fix_hi = r_rem[WIDTH-1:0];
      MD_SDIV: begin
        w_fix_lo = (r_sign_a ^ r_sign_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_fix_hi = r_sign_a ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  // NOTE: the datapath registers carry no reset; the FSM never consumes them before an accepted Start loads them.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op     <= w_op;
      r_sign_a <= w_neg_a;
      r_sign_b <= w_neg_b;
      r_rem    <= '0;
      if (md_is_div(w_op)) begin
        r_operand <= w_abs_b;
        r_acc     <= {{WIDTH{1'b0}}, w_abs_a};
      end else begin
        r_operand <= w_abs_a;
        r_acc     <= {{WIDTH{1'b0}}, w_abs_b};
      end
    end else if (r_state == S_RUN) begin
      r_acc <= w_step_acc;
      r_rem <= w_step_rem;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_divzero   <= 1'b0;
      r_result_lo <= '0;
      r_result_hi <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt     <= CW'(WIDTH - 1);
            r_busy    <= 1'b1;
            r_divzero <= 1'b0;
            if (w_div_zero) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_divzero   <= 1'b1;
              r_result_lo <= '0;
              r_result_hi <= md_if.SrcA;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (md_if.Flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_FIX: begin
          if (md_if.Flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_result_lo <= w_fix_lo;
            r_result_hi <= w_fix_hi;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign md_if.Busy     = r_busy;
  assign md_if.Done     = r_done;
  assign md_if.DivZero  = r_divzero;
  assign md_if.ResultLo = r_result_lo;
  assign md_if.ResultHi = r_result_hi;
  assign md_if.StallMD  = w_accept || (r_state == S_RUN) || (r_state == S_FIX);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected results are computed with
// native 64-bit arithmetic when an op is issued and compared on Done.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             dz;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [WIDTH-1:0] last_lo;
  logic [WIDTH-1:0] last_hi;

  muldiv_sequencer_if #(.WIDTH(WIDTH)) md_if ();

  muldiv_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .md_if (md_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    e.dz = 1'b0;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    case (op)
      2'b00: begin
        p    = {32'b0, a} * {32'b0, b};
        e.lo = p[31:0];
        e.hi = p[63:32];
      end
      2'b01: begin
        p    = 64'(sa * sb);
        e.lo = p[31:0];
        e.hi = p[63:32];
      end
      default: begin
        if (b == 0) begin
          e.lo = '0;
          e.hi = a;
          e.dz = 1'b1;
        end else if (op == 2'b10) begin
          e.lo = a / b;
          e.hi = a % b;
        end else begin
          q    = sa / sb;
          r    = sa % sb;
          e.lo = 32'(q);
          e.hi = 32'(r);
        end
      end
    endcase
    return e;
  endfunction

  // Scoreboard consumer: every Done must match the oldest pending expectation.
  always @(negedge clk) begin
    if (md_if.Done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("done_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("result_lo", 64'(md_if.ResultLo), 64'(mon_e.lo));
        check("result_hi", 64'(md_if.ResultHi), 64'(mon_e.hi));
        check("div_zero", 64'(md_if.DivZero), 64'(mon_e.dz));
      end
    end
  end

  // Issue one op and check latency and stall window; inj_cyc>0 pulses a
  // stray Start at that RUN cycle, which must be ignored.
  task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input int inj_cyc);
    exp_t e;
    int   exp_lat;
    int   stall_n;
    logic seen;
    e       = model(op, a, b);
    exp_lat = (op[1] && b == 0) ? 1 : WIDTH + 2;
    @(negedge clk);
    md_if.Start = 1'b1;
    md_if.MDOp  = op;
    md_if.SrcA  = a;
    md_if.SrcB  = b;
    sb_q.push_back(e);
    #1 check("stall_start", 64'(md_if.StallMD), 64'd1);
    stall_n = 0;
    seen    = 1'b0;
    for (int cyc = 1; cyc <= 100 && !seen; cyc++) begin
      @(negedge clk);
      if (md_if.Done === 1'b1) begin
        seen = 1'b1;
        check("latency", 64'(cyc), 64'(exp_lat));
      end else if (md_if.StallMD === 1'b1) begin
        stall_n++;
      end
      if (cyc == 1 || cyc == inj_cyc + 1) md_if.Start = 1'b0;
      if (cyc == inj_cyc) begin
        md_if.Start = 1'b1;
        md_if.MDOp  = ~op;
        md_if.SrcA  = ~a;
        md_if.SrcB  = '0;
      end
    end
    md_if.Start = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    check("stall_cycles", 64'(stall_n), 64'(exp_lat - 1));
    last_lo = e.lo;
    last_hi = e.hi;
  endtask

  task automatic flush_test();
    int dones;
    @(negedge clk);
    md_if.Start = 1'b1;
    md_if.MDOp  = MD_UMULL;
    md_if.SrcA  = 32'h1234_5678;
    md_if.SrcB  = 32'h9abc_def0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (cyc == 1) md_if.Start = 1'b0;
    end
    md_if.Flush = 1'b1;
    @(negedge clk);
    md_if.Flush = 1'b0;
    check("flush_busy", 64'(md_if.Busy), 64'd0);
    check("flush_stall", 64'(md_if.StallMD), 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (md_if.Done === 1'b1) dones++;
    end
    check("flush_no_done", 64'(dones), 64'd0);
    check("flush_keep_lo", 64'(md_if.ResultLo), 64'(last_lo));
    check("flush_keep_hi", 64'(md_if.ResultHi), 64'(last_hi));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 64'(md_if.Busy), 64'd0);
    check({tag, "_done"}, 64'(md_if.Done), 64'd0);
    check({tag, "_divzero"}, 64'(md_if.DivZero), 64'd0);
    check({tag, "_lo"}, 64'(md_if.ResultLo), 64'd0);
    check({tag, "_hi"}, 64'(md_if.ResultHi), 64'd0);
    check({tag, "_stall"}, 64'(md_if.StallMD), 64'd0);
  endtask

  initial begin
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    n_checks    = 0;
    n_fail      = 0;
    last_lo     = '0;
    last_hi     = '0;
    reset       = 1'b0;
    md_if.Start = 1'b0;
    md_if.Flush = 1'b0;
    md_if.MDOp  = 2'b00;
    md_if.SrcA  = '0;
    md_if.SrcB  = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b1;

    run_op(MD_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("umull_max_lo", 64'(last_lo), 64'h0000_0001);
    check("umull_max_hi", 64'(last_hi), 64'hFFFF_FFFE);
    run_op(MD_SMULL, 32'hFFFF_FFF9, 32'd3, 0);
    run_op(MD_SMULL, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(MD_UDIV, 32'd100, 32'd7, 0);
    run_op(MD_SDIV, 32'hFFFF_FF9C, 32'd7, 0);
    run_op(MD_SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(MD_SDIV, 32'd7, 32'hFFFF_FFFE, 0);
    run_op(MD_UDIV, 32'd5, 32'd0, 0);
    run_op(MD_UDIV, 32'd9, 32'd3, 0);
    run_op(MD_SDIV, 32'hDEAD_BEEF, 32'd0, 0);
    run_op(MD_SMULL, 32'h0001_2345, 32'hFFFF_0006, 5);
    run_op(MD_UDIV, 32'hFFFF_FFFF, 32'h0001_0001, 17);

    for (int i = 0; i < 8; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      r_b  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      run_op(r_op, r_a, r_b, 0);
    end

    flush_test();

    // Reset in the middle of RUN, after a divide-by-zero left DivZero set.
    run_op(MD_UDIV, 32'd77, 32'd0, 0);
    @(negedge clk);
    md_if.Start = 1'b1;
    md_if.MDOp  = MD_SMULL;
    md_if.SrcA  = 32'hCAFE_0001;
    md_if.SrcB  = 32'h0000_1234;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      if (cyc == 1) md_if.Start = 1'b0;
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_reset_state("run_reset");
    last_lo = '0;
    last_hi = '0;

    // Start together with Flush in IDLE must be ignored.
    @(negedge clk);
    md_if.Start = 1'b1;
    md_if.Flush = 1'b1;
    md_if.MDOp  = MD_UDIV;
    md_if.SrcA  = 32'd42;
    md_if.SrcB  = 32'd0;
    #1 check("start_flush_stall", 64'(md_if.StallMD), 64'd0);
    @(negedge clk);
    md_if.Start = 1'b0;
    md_if.Flush = 1'b0;
    check("start_flush_busy", 64'(md_if.Busy), 64'd0);
    check("start_flush_done", 64'(md_if.Done), 64'd0);
    check("start_flush_divzero", 64'(md_if.DivZero), 64'd0);

    run_op(MD_UDIV, 32'd9, 32'd3, 0);
    repeat (2) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
